// File: rtl/lbuf_pkg.sv
// Shared definitions for the line-buffer saturating adder: per-beat lane operation codes.
package lbuf_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SAT_SD = 2'b00;
  localparam mode_t MODE_SAT_UU = 2'b01;
  localparam mode_t MODE_WRAP   = 2'b10;
  localparam mode_t MODE_SUB_UU = 2'b11;

endpackage

// File: rtl/lbuf_sadd_pipe_if.sv
// Valid/ready beat bus of the saturating adder: input beat side and result side in one bundle.
interface lbuf_sadd_pipe_if
  import lbuf_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LW    = 8
);

  logic                  in_valid;
  logic                  in_ready;
  mode_t                 in_mode;
  logic [LANES*LW-1:0]   in_a;
  logic [LANES*LW-1:0]   in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*LW-1:0]   out_z;
  logic [LANES-1:0]      out_sat;

  // master = producer of input beats and consumer of results; slave = the adder
  modport master (
    output in_valid, in_mode, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_z, out_sat
  );

  modport slave (
    input  in_valid, in_mode, in_a, in_b, out_ready,
    output in_ready, out_valid, out_z, out_sat
  );

endinterface

// File: rtl/lbuf_sadd_lane.sv
// One combinational lane: (a, b, mode) -> clamped/wrapped result and saturation flag.
module lbuf_sadd_lane
  import lbuf_pkg::*;
#(
  parameter int LW = 8
) (
  input  logic [LW-1:0] a,
  input  logic [LW-1:0] b,
  input  mode_t         mode,
  output logic [LW-1:0] z,
  output logic          sat
);

  logic [LW-1:0] b_op;
  logic          ci;
  logic [LW:0]   sum;
  logic          co;
  logic [LW-1:0] s;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    b_op = b;
    ci   = 1'b0;
    z    = '0;
    sat  = 1'b0;

    if (mode == MODE_SUB_UU) begin
      b_op = ~b;
      ci   = 1'b1;
    end

    sum = {1'b0, a} + {1'b0, b_op} + (LW+1)'(ci);
    co  = sum[LW];
    s   = sum[LW-1:0];

    unique case (mode)
      MODE_SAT_SD: begin
        // carry out disagreeing with the delta's sign means we left [0, max]; carry picks the rail
        sat = co ^ b[LW-1];
        z   = sat ? {LW{co}} : s;
      end
      MODE_SAT_UU: begin
        sat = co;
        z   = sat ? {LW{1'b1}} : s;
      end
      MODE_WRAP: begin
        sat = 1'b0;
        z   = s;
      end
      MODE_SUB_UU: begin
        sat = ~co;
        z   = sat ? '0 : s;
      end
      default: begin
        sat = 1'b0;
        z   = s;
      end
    endcase
  end

endmodule

// File: rtl/lbuf_sadd_pipe.sv
// Two-stage valid/ready pipelined multi-lane saturating adder with a saturating-beat counter.
module lbuf_sadd_pipe
  import lbuf_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LW    = 8,
  parameter int CNTW  = 16
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  lbuf_sadd_pipe_if.slave      bus,
  input  logic                 cnt_clr,
  output logic [CNTW-1:0]      sat_cnt
);

  logic                s1_valid;
  mode_t               s1_mode;
  logic [LANES*LW-1:0] s1_a;
  logic [LANES*LW-1:0] s1_b;

  logic                s2_valid;
  logic [LANES*LW-1:0] s2_z;
  logic [LANES-1:0]    s2_sat;

  logic [LANES*LW-1:0] lane_z;
  logic [LANES-1:0]    lane_sat;

  logic s1_adv;
  logic s2_adv;

  // a stage may load whenever it is empty or its content moves on this cycle
  assign s2_adv       = ~s2_valid | bus.out_ready;
  assign s1_adv       = ~s1_valid | s2_adv;
  assign bus.in_ready = s1_adv;

  assign bus.out_valid = s2_valid;
  assign bus.out_z     = s2_z;
  assign bus.out_sat   = s2_sat;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lbuf_sadd_lane #(.LW(LW)) u_lane (
      .a    (s1_a[i*LW +: LW]),
      .b    (s1_b[i*LW +: LW]),
      .mode (s1_mode),
      .z    (lane_z[i*LW +: LW]),
      .sat  (lane_sat[i])
    );
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      // NOTE: data registers are reset as well so out_z/out_sat read 0 straight out of reset.
      s1_valid <= 1'b0;
      s1_mode  <= MODE_SAT_SD;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      s2_z     <= '0;
      s2_sat   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_mode <= bus.in_mode;
          s1_a    <= bus.in_a;
          s1_b    <= bus.in_b;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_z   <= lane_z;
          s2_sat <= lane_sat;
        end
      end
    end
  end

  // clear wins over a same-cycle counted handshake; the count sticks at all-ones
  always_ff @(posedge sys_clk) begin
    if (reset || cnt_clr) begin
      sat_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready && (|bus.out_sat) && (sat_cnt != {CNTW{1'b1}})) begin
      sat_cnt <= sat_cnt + CNTW'(1);
    end
  end

endmodule
